store_buffer: RTL

Posted-write buffer between the core's data-memory port and the data RAM. Stores from the core are accepted into a small circular FIFO in one cycle and drained to the RAM whenever the core is not loading. Loads that hit a buffered address are forwarded from the buffer, so the core always sees the youngest stored value. The RAM port is single-ported; loads take priority over draining.

---
 rtl/store_buffer_if.sv | 35 +++
 rtl/store_buffer.sv | 91 +++++++++
 2 files changed

// File: rtl/store_buffer_if.sv
// Core-side and RAM-side signal bundle for the store_buffer posted-write buffer.
// The buffer uses the slave modport; the core/RAM environment uses the master modport.
interface store_buffer_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Handshake: core_we/core_re are requests presented with core_addr/core_wdata.
    // A store is taken at the clock edge only when core_stall is 0; while core_stall
    // is 1 the core holds the same store request unchanged. Loads never stall.
    logic [ADDR_W-1:0] core_addr;
    logic              core_we;
    logic              core_re;
    logic [DATA_W-1:0] core_wdata;
    logic [DATA_W-1:0] core_rdata;
    logic              core_stall;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              empty;
    logic [CNT_W-1:0]  count;

    modport slave (
        input  core_addr, core_we, core_re, core_wdata, mem_rdata,
        output core_rdata, core_stall, mem_addr, mem_we, mem_wdata, empty, count
    );

    modport master (
        output core_addr, core_we, core_re, core_wdata, mem_rdata,
        input  core_rdata, core_stall, mem_addr, mem_we, mem_wdata, empty, count
    );
endinterface

// File: rtl/store_buffer.sv
// Posted-write buffer: circular FIFO of stores drained to a single-port RAM, with
// load forwarding. Define STORE_BUF_MERGE_EN to merge stores into matching entries.
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    store_buffer_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;

    logic              hit;
    logic [PTR_W-1:0]  hit_idx;
    logic              full;
    logic              drain;
    logic              merge_hit;
    logic              stall;
    logic              push;

    // Scan oldest to youngest so the last match found is the youngest entry.
    always_comb begin
        hit     = 1'b0;
        hit_idx = head;
        for (int k = 0; k < DEPTH; k++) begin
            if ((CNT_W'(k) < count) && (addr_q[head + PTR_W'(k)] == bus.core_addr)) begin
                hit     = 1'b1;
                hit_idx = head + PTR_W'(k);
            end
        end
    end

    assign full  = (count == CNT_W'(DEPTH));
    assign drain = !bus.core_re && (count != '0);

`ifdef STORE_BUF_MERGE_EN
    // A head entry leaving this cycle cannot absorb the store; allocate instead.
    assign merge_hit = bus.core_we && hit && !(drain && (hit_idx == head));
`else
    assign merge_hit = 1'b0;
`endif

    assign stall = bus.core_we && full && !merge_hit;
    assign push  = bus.core_we && !stall && !merge_hit;

    assign bus.core_rdata = hit ? data_q[hit_idx] : bus.mem_rdata;
    assign bus.core_stall = stall;
    assign bus.mem_we     = drain;
    assign bus.mem_addr   = drain ? addr_q[head] : bus.core_addr;
    assign bus.mem_wdata  = data_q[head];
    assign bus.empty      = (count == '0);
    assign bus.count      = count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (drain) begin
                head <= head + PTR_W'(1);
            end
            if (push && !drain) begin
                count <= count + CNT_W'(1);
            end else if (!push && drain) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Entry contents need no reset: validity comes from head/count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= bus.core_addr;
            data_q[tail] <= bus.core_wdata;
        end else if (merge_hit) begin
            data_q[hit_idx] <= bus.core_wdata;
        end
    end
endmodule
